// File: rtl/class_argmax_select.sv
// Captures ten signed output-layer scores on a rising 'update'. It then scans them serially,
// one compare per clock, and reports the index and value of the largest score.
module class_argmax_select #(
    parameter int bit_length = 21,
    parameter int layer_size = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  update,
    input  logic [bit_length-1:0] Y2_1,
    input  logic [bit_length-1:0] Y2_2,
    input  logic [bit_length-1:0] Y2_3,
    input  logic [bit_length-1:0] Y2_4,
    input  logic [bit_length-1:0] Y2_5,
    input  logic [bit_length-1:0] Y2_6,
    input  logic [bit_length-1:0] Y2_7,
    input  logic [bit_length-1:0] Y2_8,
    input  logic [bit_length-1:0] Y2_9,
    input  logic [bit_length-1:0] Y2_10,
    output logic [3:0]            class_index,
    output logic [bit_length-1:0] max_value,
    output logic                  valid,
    output logic                  done,
    output logic                  busy
);

    localparam logic [3:0] LAST = 4'(layer_size - 1);

    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

    state_t                                state;
    logic [layer_size-1:0][bit_length-1:0] bank;
    logic [layer_size-1:0][bit_length-1:0] y_vec;
    logic [bit_length-1:0]                 best;
    logic [bit_length-1:0]                 cur;
    logic [3:0]                            best_idx;
    logic [3:0]                            cnt;
    logic                                  update_d;
    logic                                  start;
    logic                                  take;

    assign y_vec = {Y2_10, Y2_9, Y2_8, Y2_7, Y2_6, Y2_5, Y2_4, Y2_3, Y2_2, Y2_1};

    // update_d clears in reset, so an update already high at release counts as a start
    assign start = update & ~update_d;

    always_comb begin
        cur = '0;
        for (int i = 0; i < layer_size; i++) begin
            if (cnt == 4'(i)) cur = bank[i];
        end
    end

    // strict compare keeps the lowest index on ties
    assign take = $signed(cur) > $signed(best);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bank        <= '0;
            best        <= '0;
            best_idx    <= '0;
            cnt         <= '0;
            update_d    <= 1'b0;
            class_index <= '0;
            max_value   <= '0;
            valid       <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            update_d <= update;
            case (state)
                IDLE: begin
                    if (start) begin
                        bank     <= y_vec;
                        best     <= Y2_1;
                        best_idx <= '0;
                        cnt      <= 4'd1;
                        busy     <= 1'b1;
                        valid    <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (take) begin
                        best     <= cur;
                        best_idx <= cnt;
                    end
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST) begin
                        class_index <= take ? cnt : best_idx;
                        max_value   <= take ? cur : best;
                        valid       <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= FINISH;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_class_argmax_select.sv
// Directed bench for class_argmax_select: reset, argmax patterns, ties, retrigger and abort.
module tb_class_argmax_select;

    logic        clock;
    logic        reset;
    logic        update;
    logic [20:0] sc [0:9];
    logic [3:0]  class_index;
    logic [20:0] max_value;
    logic        valid, done, busy;

    int vectors = 0;
    int miscompares = 0;

    class_argmax_select dut (
        .clock(clock), .reset(reset), .update(update),
        .Y2_1(sc[0]), .Y2_2(sc[1]), .Y2_3(sc[2]), .Y2_4(sc[3]), .Y2_5(sc[4]),
        .Y2_6(sc[5]), .Y2_7(sc[6]), .Y2_8(sc[7]), .Y2_9(sc[8]), .Y2_10(sc[9]),
        .class_index(class_index), .max_value(max_value),
        .valid(valid), .done(done), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // raise update and advance through the capture edge E0
    task automatic launch();
        update = 1'b1;
        step();
    endtask

    // after E0: step until done (bounded), dropping update after five high cycles
    task automatic wait_done(output int n);
        n = 0;
        while (n < 20) begin
            if (n == 4) update = 1'b0;
            step();
            n++;
            if (done === 1'b1) break;
        end
        update = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        update = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 10; k++) sc[k] = 21'($urandom);
            update = 1'($urandom);
            step();
            vectors++;
            if ({class_index, max_value, valid, done, busy} !== 28'd0) begin
                miscompares++;
                $display("FAIL reset_outputs[%0d]: got idx=%0d max=%h v=%b d=%b b=%b, want all 0",
                         i, class_index, max_value, valid, done, busy);
            end
        end
        update = 1'b0;
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int n;
        for (int k = 1; k <= 10; k++) sc[k-1] = 21'(k * 10);
        sc[6] = 21'd5000;
        launch();
        vectors++;
        if (busy !== 1'b1 || valid !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_e0: got b=%b v=%b d=%b, want b=1 v=0 d=0", busy, valid, done);
        end
        wait_done(n);
        vectors++;
        if (n !== 9) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d clocks, want 9", n);
        end
        vectors++;
        if (class_index !== 4'd6 || max_value !== 21'd5000 || valid !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_result: got idx=%0d max=%0d v=%b b=%b, want idx=6 max=5000 v=1 b=0",
                     class_index, max_value, valid, busy);
        end
        step();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_width: got done=%b one cycle later, want 0", done);
        end
        repeat (3) step();
        vectors++;
        if (valid !== 1'b1 || class_index !== 4'd6 || max_value !== 21'd5000) begin
            miscompares++;
            $display("FAIL basic_hold: got v=%b idx=%0d max=%0d, want v=1 idx=6 max=5000",
                     valid, class_index, max_value);
        end
    endtask

    task automatic test_negative();
        int n;
        for (int k = 1; k <= 10; k++) sc[k-1] = 21'(-(k * 100));
        launch();
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL neg_valid_clear: got valid=%b after E0, want 0", valid);
        end
        wait_done(n);
        vectors++;
        if (n !== 9 || class_index !== 4'd0 || max_value !== 21'h1FFF9C) begin
            miscompares++;
            $display("FAIL negative: got n=%0d idx=%0d max=%h, want n=9 idx=0 max=1fff9c",
                     n, class_index, max_value);
        end
        repeat (2) step();
    endtask

    task automatic test_extremes();
        int n;
        for (int k = 0; k < 10; k++) sc[k] = 21'h100000;
        sc[9] = 21'h0FFFFF;
        launch();
        wait_done(n);
        vectors++;
        if (n !== 9 || class_index !== 4'd9 || max_value !== 21'h0FFFFF) begin
            miscompares++;
            $display("FAIL extremes: got n=%0d idx=%0d max=%h, want n=9 idx=9 max=0fffff",
                     n, class_index, max_value);
        end
        repeat (2) step();
        for (int k = 0; k < 10; k++) sc[k] = 21'(k * 10);
        sc[2] = 21'd1000;
        sc[7] = 21'd1000;
        launch();
        wait_done(n);
        vectors++;
        if (n !== 9 || class_index !== 4'd2 || max_value !== 21'd1000) begin
            miscompares++;
            $display("FAIL tie: got n=%0d idx=%0d max=%0d, want n=9 idx=2 max=1000",
                     n, class_index, max_value);
        end
        repeat (2) step();
        for (int k = 0; k < 10; k++) sc[k] = 21'h100000;
        launch();
        wait_done(n);
        vectors++;
        if (class_index !== 4'd0 || max_value !== 21'h100000) begin
            miscompares++;
            $display("FAIL all_min: got idx=%0d max=%h, want idx=0 max=100000", class_index, max_value);
        end
        repeat (2) step();
    endtask

    task automatic test_retrigger();
        int pulses = 0;
        int first_at = 0;
        logic [3:0]  got_idx = '0;
        logic [20:0] got_max = '0;
        for (int k = 1; k <= 10; k++) sc[k-1] = 21'(k * 10);
        sc[6] = 21'd5000;
        launch();
        for (int n = 1; n <= 24; n++) begin
            if (n == 2) update = 1'b0;
            if (n == 4) begin
                for (int k = 0; k < 10; k++) sc[k] = 21'd9;
                sc[0] = 21'd90000;
                update = 1'b1;
            end
            step();
            if (done === 1'b1) begin
                pulses++;
                if (first_at == 0) begin
                    first_at = n;
                    got_idx = class_index;
                    got_max = max_value;
                end
            end
        end
        update = 1'b0;
        vectors++;
        if (pulses !== 1 || first_at !== 9) begin
            miscompares++;
            $display("FAIL retrigger_pulses: got %0d pulses first at %0d, want 1 at 9", pulses, first_at);
        end
        vectors++;
        if (got_idx !== 4'd6 || got_max !== 21'd5000) begin
            miscompares++;
            $display("FAIL retrigger_result: got idx=%0d max=%0d, want idx=6 max=5000", got_idx, got_max);
        end
        repeat (2) step();
    endtask

    task automatic test_abort();
        int n;
        int pulses = 0;
        for (int k = 0; k < 10; k++) sc[k] = 21'(k);
        launch();
        update = 1'b0;
        repeat (3) step();
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({class_index, max_value, valid, done, busy} !== 28'd0) begin
            miscompares++;
            $display("FAIL abort_outputs: got idx=%0d max=%h v=%b d=%b b=%b, want all 0",
                     class_index, max_value, valid, done, busy);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (done !== 1'b0) pulses++;
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done !== 1'b0) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d done cycles, want 0", pulses);
        end
        for (int k = 0; k < 10; k++) sc[k] = 21'(-(k * 3));
        sc[4] = 21'd77;
        launch();
        wait_done(n);
        vectors++;
        if (n !== 9 || class_index !== 4'd4 || max_value !== 21'd77 || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_recover: got n=%0d idx=%0d max=%0d v=%b, want n=9 idx=4 max=77 v=1",
                     n, class_index, max_value, valid);
        end
        repeat (2) step();
    endtask

    initial begin
        reset = 1'b0;
        update = 1'b0;
        for (int k = 0; k < 10; k++) sc[k] = '0;
        test_reset();
        test_basic();
        test_negative();
        test_extremes();
        test_retrigger();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
